// File: rtl/hbm_pkg.sv
// Shared HBM definitions: run states, burst-length limits and
// the byte-address width shared with the parameter register block.
package hbm_pkg;

  localparam int ADDR_W_DEF = 33;
  localparam int LEN_W_DEF  = 8;
  localparam int MAX_BURST  = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Beats-per-burst to AXI arlen: 0 acts as 1, >256 clips to 256.
  function automatic logic [LEN_W_DEF-1:0] burst_len(
    input logic [15:0] bs
  );
    logic [15:0] t;
    t = bs - 16'd1;
    if (bs == 16'd0)
      return '0;
    else if (bs > 16'(MAX_BURST))
      return '1;
    else
      return t[LEN_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/hbm_read_addr_gen.sv
// HBM pseudo-channel read-address generator: issues ops AXI AR bursts
// at init_addr + i*stride. Ports: start/descriptor in, AR channel out,
// busy/done/issued_count status out.
module hbm_read_addr_gen
  import hbm_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int LEN_WIDTH  = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           ops,
  input  logic [31:0]           stride,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [15:0]           mem_burst_size,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [LEN_WIDTH-1:0]  arlen,
  output logic                  arvalid,
  input  logic                  arready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           issued_count
);

  state_t      state;
  logic [31:0] ops_r;
  logic [31:0] stride_r;
  logic        last;

  assign last = (issued_count == ops_r - 32'd1);

  // araddr doubles as the running address; arlen holds the latched length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ops_r        <= '0;
      stride_r     <= '0;
      araddr       <= '0;
      arlen        <= '0;
      arvalid      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issued_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ops_r        <= ops;
            stride_r     <= stride;
            araddr       <= init_addr;
            arlen        <= LEN_WIDTH'(burst_len(mem_burst_size));
            issued_count <= '0;
            if (ops == 32'd0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state   <= ISSUE;
              arvalid <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (arready) begin
            issued_count <= issued_count + 32'd1;
            araddr       <= araddr + ADDR_WIDTH'(stride_r);
            if (last) begin
              state   <= FINISH;
              arvalid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          arvalid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
